// File: rtl/icg_enable_ctrl.sv
// Clock-gate enable sequencer: wakes the gated clock on REQ, holds it through IDLE, gates off after a quiet period.
// All outputs registered; ACK follows a fixed WAKE_CYCLES delay, gate-off follows IDLE_CYCLES quiet edges.
module icg_enable_ctrl #(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ,
    input  logic       BUSY,
    input  logic       SCAN,
    input  logic       CLR,
    output logic       E,
    output logic       TE,
    output logic       ACK,
    output logic [7:0] OFF_CNT
);

    typedef enum logic [1:0] {S_OFF, S_WAKE, S_ON, S_IDLE} state_t;

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             gate_off;

    // The edge that takes IDLE to OFF is the only event OFF_CNT counts.
    always_comb begin
        gate_off = (state == S_IDLE) && !REQ && !BUSY && (cnt == '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_OFF;
            cnt   <= '0;
            E     <= 1'b0;
            ACK   <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    if (REQ) begin
                        state <= S_WAKE;
                        cnt   <= WAKE_LOAD;
                        E     <= 1'b1;
                        ACK   <= 1'b0;
                    end
                end
                S_WAKE: begin
                    if (cnt == '0) begin
                        state <= S_ON;
                        ACK   <= REQ;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (!REQ && !BUSY) begin
                        state <= S_IDLE;
                        cnt   <= IDLE_LOAD;
                        ACK   <= 1'b0;
                    end else begin
                        ACK <= REQ;
                    end
                end
                S_IDLE: begin
                    // Any activity returns straight to ON; the clock never stopped, so no wake delay.
                    if (REQ || BUSY) begin
                        state <= S_ON;
                        ACK   <= REQ;
                    end else if (cnt == '0) begin
                        state <= S_OFF;
                        E     <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_OFF;
                    E     <= 1'b0;
                    ACK   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TE      <= 1'b0;
            OFF_CNT <= 8'd0;
        end else begin
            TE <= SCAN;
            if (CLR) begin
                OFF_CNT <= 8'd0;
            end else if (gate_off && (OFF_CNT != 8'hFF)) begin
                OFF_CNT <= OFF_CNT + 8'd1;
            end
        end
    end

endmodule
